// File: rtl/tribus_rx_keeper.sv
// tribus_rx_keeper: receiver/keeper for a shared inverting tristate bus segment with settle capture, float timeout and contention flag
module tribus_rx_keeper #(
    parameter int WIDTH    = 8,
    parameter int NDRV     = 4,
    parameter int SETTLE   = 2,
    parameter int FLOAT_TO = 15
) (
    input  logic                                               CLK,
    input  logic                                               RST,
    input  logic [WIDTH-1:0]                                   BUS,
    input  logic [NDRV-1:0]                                    EN_VEC,
    input  logic                                               READY,
    input  logic                                               CONT_CLR,
    output logic [WIDTH-1:0]                                   Q,
    output logic [(($clog2(NDRV) > 1) ? $clog2(NDRV) : 1)-1:0] DRV_ID,
    output logic                                               Q_VLD,
    output logic                                               FLOAT,
    output logic                                               CONT
);
    localparam int IW = ($clog2(NDRV) > 1) ? $clog2(NDRV) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam int FW = $clog2(FLOAT_TO + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_OFFER, S_RELEASE, S_ERR} state_t;

    state_t          state, state_n;
    logic [WIDTH-1:0] bus_s;
    logic [NDRV-1:0]  en_s;
    logic [WIDTH-1:0] cand, cand_n;
    logic [IW-1:0]    cdrv, cdrv_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [FW-1:0]    fcnt;
    logic [WIDTH-1:0] q_n;
    logic [IW-1:0]    id_n;
    logic             vld_n;
    logic [IW-1:0]    idx;
    logic             none, multi, driven, match, take;

    // input sample stage: every decision below looks only at these registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus_s <= '0;
            en_s  <= '0;
        end else begin
            bus_s <= BUS;
            en_s  <= EN_VEC;
        end
    end

    // classify the sample and encode the index of the single active driver
    always_comb begin
        none   = ~|en_s;
        multi  = |(en_s & (en_s - NDRV'(1)));
        driven = !none && !multi;
        idx    = '0;
        for (int i = 0; i < NDRV; i++)
            if (en_s[i]) idx = IW'(i);
        match  = driven && idx == cdrv && bus_s == cand;
    end

    // next-state and next-output logic of the capture FSM
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cdrv_n  = cdrv;
        cnt_n   = cnt;
        q_n     = Q;
        id_n    = DRV_ID;
        vld_n   = Q_VLD;
        take    = 1'b0;
        case (state)
            S_IDLE: begin
                if (multi) state_n = S_ERR;
                else if (driven) begin
                    cand_n  = bus_s;
                    cdrv_n  = idx;
                    cnt_n   = CW'(1);
                    state_n = S_SETTLE;
                    take    = CW'(1) == CW'(SETTLE);
                end
            end
            S_SETTLE: begin
                if (multi) state_n = S_ERR;
                else if (none) state_n = S_IDLE;
                else begin
                    cand_n = bus_s;
                    cdrv_n = idx;
                    cnt_n  = match ? cnt + CW'(1) : CW'(1);
                    take   = cnt_n == CW'(SETTLE);
                end
            end
            S_OFFER: begin
                if (READY) begin
                    vld_n   = 1'b0;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (multi) state_n = S_ERR;
                else if (none) state_n = S_IDLE;
                else if (!match) begin
                    cand_n  = bus_s;
                    cdrv_n  = idx;
                    cnt_n   = CW'(1);
                    state_n = S_SETTLE;
                    take    = CW'(1) == CW'(SETTLE);
                end
            end
            S_ERR: begin
                if (none) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (take) begin
            q_n     = ~bus_s;
            id_n    = idx;
            vld_n   = 1'b1;
            state_n = S_OFFER;
        end
    end

    // FSM and capture registers; Q keeps its value after the handshake
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            cand   <= '0;
            cdrv   <= '0;
            cnt    <= '0;
            Q      <= '0;
            DRV_ID <= '0;
            Q_VLD  <= 1'b0;
        end else begin
            state  <= state_n;
            cand   <= cand_n;
            cdrv   <= cdrv_n;
            cnt    <= cnt_n;
            Q      <= q_n;
            DRV_ID <= id_n;
            Q_VLD  <= vld_n;
        end
    end

    // saturating run length of undriven samples
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) fcnt <= '0;
        else if (!none) fcnt <= '0;
        else if (fcnt != FW'(FLOAT_TO)) fcnt <= fcnt + FW'(1);
    end

    assign FLOAT = fcnt == FW'(FLOAT_TO);

    // sticky contention flag; a contention sample beats a clear request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) CONT <= 1'b0;
        else if (multi) CONT <= 1'b1;
        else if (CONT_CLR) CONT <= 1'b0;
    end
endmodule

// File: tb/tb_tribus_rx_keeper.sv
// tb_tribus_rx_keeper: scoreboard bench for the tristate bus receiver/keeper
module tb_tribus_rx_keeper;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] BUS = '0;
    logic [3:0] EN_VEC = '0;
    logic       READY = 1'b0;
    logic       CONT_CLR = 1'b0;
    logic [7:0] Q;
    logic [1:0] DRV_ID;
    logic       Q_VLD, FLOAT, CONT;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];
    logic [9:0] exp_w;

    tribus_rx_keeper #(.WIDTH(8), .NDRV(4), .SETTLE(2), .FLOAT_TO(15)) dut (
        .CLK(CLK), .RST(RST), .BUS(BUS), .EN_VEC(EN_VEC), .READY(READY),
        .CONT_CLR(CONT_CLR), .Q(Q), .DRV_ID(DRV_ID), .Q_VLD(Q_VLD),
        .FLOAT(FLOAT), .CONT(CONT)
    );

    always #5 CLK = ~CLK;

    task tick;
        @(posedge CLK);
        #1;
    endtask

    task do_reset;
        BUS = '0;
        EN_VEC = '0;
        READY = 1'b0;
        CONT_CLR = 1'b0;
        #2 RST = 1'b1;
        #3 RST = 1'b0;
        sb.delete();
        tick;
    endtask

    task test_reset;
        RST = 1'b1;
        tick;
        tick;
        RST = 1'b0;
        checks++;
        if ({Q, DRV_ID, Q_VLD, FLOAT, CONT} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got Q=%h id=%0d vld=%b float=%b cont=%b want all 0", Q, DRV_ID, Q_VLD, FLOAT, CONT);
        end
        do_reset;
        EN_VEC = 4'b0010;
        BUS = 8'hA5;
        tick; tick; tick;
        checks++;
        if (!Q_VLD || Q !== 8'h5A || DRV_ID !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_capture got vld=%b Q=%h id=%0d want 1 5a 1", Q_VLD, Q, DRV_ID);
        end
        EN_VEC = 4'b0011;
        tick; tick;
        EN_VEC = 4'b0010;
        checks++;
        if (!CONT || !Q_VLD || Q !== 8'h5A) begin
            errors++;
            $display("FAIL offer_contention got cont=%b vld=%b Q=%h want 1 1 5a", CONT, Q_VLD, Q);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (Q !== 8'h00 || Q_VLD !== 1'b0 || CONT !== 1'b0 || FLOAT !== 1'b0) begin
            errors++;
            $display("FAIL mid_offer_reset got Q=%h vld=%b cont=%b float=%b want 00 0 0 0", Q, Q_VLD, CONT, FLOAT);
        end
        #2 RST = 1'b0;
        sb.delete();
        tick;
    endtask

    task test_single_capture;
        do_reset;
        EN_VEC = 4'b0100;
        BUS = 8'h3C;
        sb.push_back({8'hC3, 2'd2});
        tick; tick;
        checks++;
        if (Q_VLD !== 1'b0) begin
            errors++;
            $display("FAIL single_early got vld=%b after edge 2 want 0", Q_VLD);
        end
        tick;
        exp_w = sb.pop_front();
        checks++;
        if (Q_VLD !== 1'b1 || {Q, DRV_ID} !== exp_w) begin
            errors++;
            $display("FAIL single_capture got vld=%b Q=%h id=%0d want 1 %h %0d", Q_VLD, Q, DRV_ID, exp_w[9:2], exp_w[1:0]);
        end
        BUS = 8'h77;
        EN_VEC = 4'b0001;
        tick; tick; tick;
        checks++;
        if (Q_VLD !== 1'b1 || {Q, DRV_ID} !== exp_w) begin
            errors++;
            $display("FAIL single_hold got vld=%b Q=%h id=%0d want 1 %h %0d", Q_VLD, Q, DRV_ID, exp_w[9:2], exp_w[1:0]);
        end
        READY = 1'b1;
        tick;
        READY = 1'b0;
        checks++;
        if (Q_VLD !== 1'b0 || Q !== 8'hC3) begin
            errors++;
            $display("FAIL single_handshake got vld=%b Q=%h want 0 c3", Q_VLD, Q);
        end
    endtask

    task test_glitch_restart;
        do_reset;
        EN_VEC = 4'b0001;
        BUS = 8'h00;
        tick;
        BUS = 8'hFF;
        sb.push_back({8'h00, 2'd0});
        tick; tick;
        checks++;
        if (Q_VLD !== 1'b0) begin
            errors++;
            $display("FAIL glitch_edge3 got vld=%b want 0", Q_VLD);
        end
        tick;
        exp_w = sb.pop_front();
        checks++;
        if (Q_VLD !== 1'b1 || {Q, DRV_ID} !== exp_w) begin
            errors++;
            $display("FAIL glitch_edge4 got vld=%b Q=%h id=%0d want 1 %h %0d", Q_VLD, Q, DRV_ID, exp_w[9:2], exp_w[1:0]);
        end
    endtask

    task test_no_recapture;
        int n;
        logic seen;
        READY = 1'b1;
        tick;
        READY = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            seen = seen | Q_VLD;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL no_recapture got vld seen=%b want 0", seen);
        end
        BUS = 8'h01;
        sb.push_back({8'hFE, 2'd0});
        n = 0;
        while (!Q_VLD && n < 10) begin
            tick;
            n++;
        end
        exp_w = sb.pop_front();
        checks++;
        if (Q_VLD !== 1'b1 || {Q, DRV_ID} !== exp_w) begin
            errors++;
            $display("FAIL new_capture got vld=%b Q=%h id=%0d want 1 %h %0d", Q_VLD, Q, DRV_ID, exp_w[9:2], exp_w[1:0]);
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL new_capture_latency got %0d edges want 3", n);
        end
    endtask

    task test_contention;
        logic seen;
        do_reset;
        EN_VEC = 4'b0011;
        BUS = 8'h11;
        tick;
        EN_VEC = 4'b0100;
        tick;
        checks++;
        if (CONT !== 1'b1 || Q_VLD !== 1'b0) begin
            errors++;
            $display("FAIL contention_set got cont=%b vld=%b want 1 0", CONT, Q_VLD);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            seen = seen | Q_VLD;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL err_blocks_capture got vld seen=%b want 0", seen);
        end
        EN_VEC = 4'b1100;
        CONT_CLR = 1'b1;
        tick; tick;
        checks++;
        if (CONT !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_contention got cont=%b want 1", CONT);
        end
        EN_VEC = 4'b0000;
        tick; tick;
        CONT_CLR = 1'b0;
        checks++;
        if (CONT !== 1'b0) begin
            errors++;
            $display("FAIL contention_clear got cont=%b want 0", CONT);
        end
        EN_VEC = 4'b0100;
        BUS = 8'h11;
        sb.push_back({8'hEE, 2'd2});
        tick; tick; tick;
        exp_w = sb.pop_front();
        checks++;
        if (Q_VLD !== 1'b1 || {Q, DRV_ID} !== exp_w) begin
            errors++;
            $display("FAIL capture_after_err got vld=%b Q=%h id=%0d want 1 %h %0d", Q_VLD, Q, DRV_ID, exp_w[9:2], exp_w[1:0]);
        end
    endtask

    task test_float;
        do_reset;
        EN_VEC = 4'b0001;
        tick; tick;
        EN_VEC = 4'b0000;
        for (int i = 0; i < 15; i++) tick;
        checks++;
        if (FLOAT !== 1'b0) begin
            errors++;
            $display("FAIL float_early got float=%b after 14 counted samples want 0", FLOAT);
        end
        tick;
        checks++;
        if (FLOAT !== 1'b1) begin
            errors++;
            $display("FAIL float_set got float=%b after 15 counted samples want 1", FLOAT);
        end
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (FLOAT !== 1'b1) begin
            errors++;
            $display("FAIL float_saturate got float=%b want 1", FLOAT);
        end
        EN_VEC = 4'b0100;
        tick;
        EN_VEC = 4'b0000;
        checks++;
        if (FLOAT !== 1'b1) begin
            errors++;
            $display("FAIL float_before_drop got float=%b want 1", FLOAT);
        end
        tick;
        checks++;
        if (FLOAT !== 1'b0) begin
            errors++;
            $display("FAIL float_drop got float=%b want 0", FLOAT);
        end
        tick;
        checks++;
        if (FLOAT !== 1'b0) begin
            errors++;
            $display("FAIL float_restart got float=%b want 0", FLOAT);
        end
    endtask

    task test_back_to_back;
        logic [3:0] ens[3] = '{4'b0001, 4'b1000, 4'b0010};
        logic [7:0] dat[3] = '{8'h96, 8'h0F, 8'hE1};
        logic [1:0] ids[3] = '{2'd0, 2'd3, 2'd1};
        int n;
        do_reset;
        for (int k = 0; k < 3; k++) begin
            EN_VEC = ens[k];
            BUS = dat[k];
            sb.push_back({~dat[k], ids[k]});
            n = 0;
            while (!Q_VLD && n < 10) begin
                tick;
                n++;
            end
            checks++;
            if (!Q_VLD) begin
                errors++;
                $display("FAIL b2b_timeout word %0d got no vld within 10 edges", k);
            end else begin
                exp_w = sb.pop_front();
                checks++;
                if ({Q, DRV_ID} !== exp_w) begin
                    errors++;
                    $display("FAIL b2b_word%0d got Q=%h id=%0d want %h %0d", k, Q, DRV_ID, exp_w[9:2], exp_w[1:0]);
                end
            end
            READY = 1'b1;
            tick;
            READY = 1'b0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover got %0d queued want 0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_single_capture;
        test_glitch_restart;
        test_no_recapture;
        test_contention;
        test_float;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
